// File: rtl/msl_slave_receiver.sv
// MSL single-wire frame receiver: synchronises the line, measures run lengths in i_clk
// cycles and rebuilds the parallel word, flagging malformed frames with a cause code.
module msl_slave_receiver #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_SYSTEM_CLK = 50_000_000,
  parameter int unsigned P_IDLE_TICKS = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_msl_sda,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_data_valid,
  output logic                    o_frame_err,
  output logic [1:0]              o_err_code,
  output logic                    o_busy
);

  localparam int unsigned U        = P_SYSTEM_CLK / 1000;
  localparam int unsigned L_MIN    = 3 * U;
  localparam int unsigned L_SPLIT  = (15 * U) / 2;
  localparam int unsigned L_MAX    = 13 * U;
  localparam int unsigned IDLE_THR = P_IDLE_TICKS * U;
  localparam int unsigned IDLE_SAT = (IDLE_THR > L_MIN) ? IDLE_THR : L_MIN;
  localparam int unsigned RW       = $clog2(L_MAX + 1);
  localparam int unsigned IW       = $clog2(IDLE_SAT + 1);
  localparam int unsigned BW       = (P_DATA_WIDTH > 2) ? $clog2(P_DATA_WIDTH) : 1;

  // r_run holds (run length - 1) while a level is stable, so thresholds compare against L-1
  localparam logic [RW-1:0] RUN_MIN_M1   = RW'(L_MIN - 1);
  localparam logic [RW-1:0] RUN_SPLIT_M1 = RW'(L_SPLIT - 1);
  localparam logic [RW-1:0] RUN_MAX_M1   = RW'(L_MAX - 1);
  localparam logic [RW-1:0] RUN_MAX      = RW'(L_MAX);
  localparam logic [IW-1:0] IDLE_QUAL    = IW'(IDLE_THR);
  localparam logic [IW-1:0] IDLE_TOP     = IW'(IDLE_SAT);
  localparam logic [IW-1:0] IDLE_AFTER   = IW'(L_MIN);
  localparam logic [BW-1:0] LAST_BIT     = BW'(P_DATA_WIDTH - 1);

  if ((P_DATA_WIDTH % 2) != 0) begin : g_width_check
    $error("msl_slave_receiver: P_DATA_WIDTH must be even");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LO,
    S_START_HI,
    S_DATA,
    S_STOP_LO,
    S_STOP_HI
  } state_t;

  state_t                  state, state_nxt;
  logic                    sda_meta, sda_sync, sda_prev;
  logic                    line_edge, line_fall;
  logic [RW-1:0]           r_run;
  logic [IW-1:0]           idle_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [P_DATA_WIDTH-1:0] shift_reg;
  logic                    run_glitch, run_short, run_timeout;
  logic                    done, err, seg_ok, seg_bit;
  logic [1:0]              err_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      sda_meta <= i_msl_sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  assign line_edge   = sda_sync ^ sda_prev;
  assign line_fall   = sda_prev & ~sda_sync;
  assign run_glitch  = (r_run < RUN_MIN_M1);
  assign run_short   = (r_run < RUN_SPLIT_M1);
  assign run_timeout = (r_run >= RUN_MAX_M1);
  assign o_busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    err_code  = 2'd0;
    seg_ok    = 1'b0;
    seg_bit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (line_fall && (idle_cnt >= IDLE_QUAL)) state_nxt = S_START_LO;
      end
      S_STOP_HI: begin
        if (r_run == RUN_MIN_M1) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (line_edge) begin
          err       = 1'b1;
          err_code  = 2'd1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        // timeout outranks an edge arriving in the same cycle the run hits L_MAX
        if (run_timeout) begin
          err       = 1'b1;
          err_code  = 2'd3;
          state_nxt = S_IDLE;
        end else if (line_edge) begin
          if (run_glitch) begin
            err       = 1'b1;
            err_code  = 2'd1;
            state_nxt = S_IDLE;
          end else if (state == S_DATA) begin
            seg_ok  = 1'b1;
            seg_bit = ~run_short;
            if (bit_cnt == LAST_BIT) state_nxt = S_STOP_LO;
          end else if (!run_short) begin
            err       = 1'b1;
            err_code  = 2'd2;
            state_nxt = S_IDLE;
          end else begin
            case (state)
              S_START_LO: state_nxt = S_START_HI;
              S_START_HI: state_nxt = S_DATA;
              S_STOP_LO:  state_nxt = S_STOP_HI;
              default:    state_nxt = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run     <= '0;
      idle_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (line_edge) begin
        r_run <= '0;
      end else if (r_run != RUN_MAX) begin
        r_run <= r_run + 1'b1;
      end

      if (err) begin
        idle_cnt <= '0;
      end else if (done) begin
        idle_cnt <= IDLE_AFTER;
      end else if (!sda_sync) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_TOP) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (seg_ok) begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= {shift_reg[P_DATA_WIDTH-2:0], seg_bit};
      end else if (state != S_DATA) begin
        bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= 2'd0;
    end else begin
      o_data_valid <= done;
      o_frame_err  <= err;
      if (done) begin
        o_data     <= shift_reg;
        o_err_code <= 2'd0;
      end else if (err) begin
        o_err_code <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_msl_slave_receiver.sv
// Directed bench for msl_slave_receiver with U = 10 cycles; the line is driven cycle-exact
// on the falling clock edge and outputs are observed on the falling edge.
module tb_msl_slave_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, busy;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] data_log [0:63];

  msl_slave_receiver #(
    .P_DATA_WIDTH(8),
    .P_SYSTEM_CLK(10_000),
    .P_IDLE_TICKS(10)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_msl_sda   (sda),
    .o_data      (data),
    .o_data_valid(data_valid),
    .o_frame_err (frame_err),
    .o_err_code  (err_code),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      data_log[valid_cnt % 64] <= data;
      valid_cnt <= valid_cnt + 1;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    sda = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_segs(input int seg [8], input int gap_ticks);
    drive(1'b0, 50);
    drive(1'b1, 50);
    for (int i = 0; i < 8; i++) drive(((i % 2) == 1), seg[i]);
    drive(1'b0, 50);
    drive(1'b1, gap_ticks * 10);
  endtask

  task automatic send_frame(input logic [7:0] d, input int gap_ticks);
    int seg [8];
    for (int i = 0; i < 8; i++) seg[i] = d[7-i] ? 100 : 50;
    send_segs(seg, gap_ticks);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, b0, lat;
    int seg_a [8];
    int seg_b [8];

    repeat (3) @(negedge clk);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_valid", data_valid, 1'b0);
    check_eq("rst_err", frame_err, 1'b0);
    check_eq("rst_code", err_code, 2'd0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // 1: qualified idle then 0xA5; busy spans 150 + 600 data + 30 stop-high cycles
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_cnt;
    drive(1'b1, 300);
    send_frame(8'hA5, 26);
    check_eq("t1_valid_cnt", valid_cnt - v0, 1);
    check_eq("t1_data", data_log[v0 % 64], 8'hA5);
    check_eq("t1_code", err_code, 2'd0);
    check_eq("t1_err_cnt", err_cnt - e0, 0);
    check_eq("t1_busy_cycles", busy_cnt - b0, 780);

    // 2: back-to-back frames with minimum sender gap
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h00, 26);
    send_frame(8'hFF, 26);
    check_eq("t2_valid_cnt", valid_cnt - v0, 2);
    check_eq("t2_data0", data_log[v0 % 64], 8'h00);
    check_eq("t2_data1", data_log[(v0 + 1) % 64], 8'hFF);
    check_eq("t2_err_cnt", err_cnt - e0, 0);

    // 3: segment boundaries: 74 -> 0, 75 -> 1, 30 -> 0, 129 -> 1
    v0 = valid_cnt; e0 = err_cnt;
    seg_a = '{74, 75, 30, 50, 50, 50, 50, 50};
    seg_b = '{50, 50, 50, 50, 50, 50, 129, 74};
    send_segs(seg_a, 26);
    send_segs(seg_b, 26);
    check_eq("t3_valid_cnt", valid_cnt - v0, 2);
    check_eq("t3_data_74_75", data_log[v0 % 64], 8'h40);
    check_eq("t3_data_129_74", data_log[(v0 + 1) % 64], 8'h02);
    check_eq("t3_err_cnt", err_cnt - e0, 0);

    // 4: 1-tick high pulse inside the first low data segment
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b0, 50);
    drive(1'b1, 50);
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 30);
    drive(1'b1, 300);
    check_eq("t4_err_cnt", err_cnt - e0, 1);
    check_eq("t4_code", err_code, 2'd1);
    check_eq("t4_valid_cnt", valid_cnt - v0, 0);
    check_eq("t4_data_kept", data, 8'h02);

    // 5a: line stuck low after start-high; 130 cycles plus 3 cycles of sync/edge registers
    e0 = err_cnt;
    drive(1'b0, 50);
    drive(1'b1, 50);
    sda = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (frame_err && (lat < 0)) lat = k;
    end
    check_eq("t5_timeout_latency", lat, 133);
    check_eq("t5_timeout_code", err_code, 2'd3);
    drive(1'b1, 300);
    // 5b: start-low of 10 ticks is a format error
    drive(1'b0, 100);
    drive(1'b1, 300);
    check_eq("t5_err_cnt", err_cnt - e0, 2);
    check_eq("t5_format_code", err_code, 2'd2);

    // 6a: reset, then a falling edge after only 4 ticks high is ignored
    rst_n = 1'b0;
    sda = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt; b0 = busy_cnt;
    drive(1'b1, 40);
    drive(1'b0, 50);
    drive(1'b1, 50);
    drive(1'b0, 50);
    drive(1'b1, 300);
    check_eq("t6_ignored_busy", busy_cnt - b0, 0);
    check_eq("t6_ignored_err", err_cnt - e0, 0);
    v0 = valid_cnt;
    send_frame(8'h5A, 26);
    check_eq("t6_pre_data", data_log[v0 % 64], 8'h5A);

    // 6b: reset in the middle of the data field
    drive(1'b0, 50);
    drive(1'b1, 50);
    drive(1'b0, 50);
    drive(1'b1, 100);
    drive(1'b0, 30);
    check_eq("t6_busy_mid", busy, 1'b1);
    rst_n = 1'b0;
    sda = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_data", data, 8'h00);
    check_eq("t6_rst_valid", data_valid, 1'b0);
    check_eq("t6_rst_err", frame_err, 1'b0);
    check_eq("t6_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    drive(1'b1, 110);
    send_frame(8'h3C, 26);
    check_eq("t6_valid_cnt", valid_cnt - v0, 1);
    check_eq("t6_data", data_log[v0 % 64], 8'h3C);
    check_eq("t6_code", err_code, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
